// File: rtl/spike_encoder.sv
// Temporal spike encoder: one spike-time code per line is replayed as a single
// spike inside a 2**TIME_BITS-cycle gamma window started by grst.
module spike_encoder #(
   parameter int NUM_INPUTS = 2,
   parameter int TIME_BITS  = 3
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            grst,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [NUM_INPUTS*TIME_BITS-1:0] in_data,
   output logic [NUM_INPUTS-1:0]           spikes_out,
   output logic                            busy,
   output logic                            window_done,
   output logic                            trunc
);

   localparam int DW = NUM_INPUTS * TIME_BITS;
   // The last slot index doubles as the "no spike" code.
   localparam logic [TIME_BITS-1:0] LAST = '1;

   typedef enum logic {S_IDLE, S_ACTIVE} state_t;

   state_t               r_state, w_state_nxt;
   logic [TIME_BITS-1:0] r_count, w_count_nxt;
   logic [DW-1:0]        r_active;
   logic [DW-1:0]        r_pending;
   logic                 r_pend_full;
   logic                 w_xfer;
   logic                 w_load;
   logic                 w_last;
   logic                 w_busy;
   logic [NUM_INPUTS-1:0] w_spikes;

   assign in_ready = ~r_pend_full;
   assign w_xfer   = in_valid & ~r_pend_full;
   assign w_load   = grst & r_pend_full;
   assign w_last   = (r_count == LAST);
   assign w_busy   = (r_state == S_ACTIVE);

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      if (grst) begin
         w_count_nxt = '0;
         w_state_nxt = r_pend_full ? S_ACTIVE : S_IDLE;
      end else if (r_state == S_ACTIVE) begin
         if (w_last) begin
            w_state_nxt = S_IDLE;
            w_count_nxt = '0;
         end else begin
            w_count_nxt = r_count + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
      end
   end

   // A restart with nothing pending leaves an all-silent active word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_active <= '1;
      end else if (grst) begin
         r_active <= r_pend_full ? r_pending : '1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend_full <= 1'b0;
         r_pending   <= '0;
      end else begin
         if (w_load) begin
            r_pend_full <= 1'b0;
         end
         if (w_xfer) begin
            r_pend_full <= 1'b1;
            r_pending   <= in_data;
         end
      end
   end

   always_comb begin
      w_spikes = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         w_spikes[i] = w_busy
                       && (r_count == r_active[i*TIME_BITS +: TIME_BITS])
                       && (r_active[i*TIME_BITS +: TIME_BITS] != LAST);
      end
   end

   assign spikes_out  = w_spikes;
   assign busy        = w_busy;
   assign window_done = w_busy & w_last & ~grst;
   assign trunc       = grst & w_busy & ~w_last;

endmodule

// File: tb/tb_spike_encoder.sv
// Directed bench for spike_encoder (2 lines, 3-bit codes, 8-slot window) with
// a spike scoreboard filled when a window is started and drained per cycle.
module tb_spike_encoder;

   logic       clk = 1'b0;
   logic       rst;
   logic       grst;
   logic       in_valid;
   logic       in_ready;
   logic [5:0] in_data;
   logic [1:0] spikes_out;
   logic       busy;
   logic       window_done;
   logic       trunc;

   spike_encoder #(.NUM_INPUTS(2), .TIME_BITS(3)) dut (
      .clk(clk), .rst(rst), .grst(grst), .in_valid(in_valid),
      .in_ready(in_ready), .in_data(in_data), .spikes_out(spikes_out),
      .busy(busy), .window_done(window_done), .trunc(trunc)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [1:0] val;
   } ev_t;

   ev_t        q[$];
   int         n_assert = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   int         ws       = -100;
   int         we       = -100;
   logic       pf       = 1'b0;
   logic [5:0] pw       = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic push_window(input int c, input logic [5:0] w);
      logic [5:0] word;
      logic [1:0] v;
      word = w;
      for (int t = 0; t < 7; t++) begin
         v = 2'b00;
         for (int i = 0; i < 2; i++)
            if (word[i*3 +: 3] == t[2:0]) v[i] = 1'b1;
         if (v != 2'b00) q.push_back('{c + 1 + t, v});
      end
   endtask

   task automatic offer(input logic [5:0] w);
      in_valid = 1'b1;
      in_data  = w;
   endtask

   // Each cycle: check outputs at negedge, advance model, step past posedge.
   task automatic run(input int n);
      logic [1:0] exp_sp;
      logic       eb, xfer;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         exp_sp = 2'b00;
         if (q.size() > 0 && q[0].cyc == cyc) exp_sp = q.pop_front().val;
         eb = (cyc >= ws) && (cyc <= we);
         chk("spikes", 32'(spikes_out), 32'(exp_sp));
         chk("busy", 32'(busy), 32'(eb));
         chk("window_done", 32'(window_done), 32'(eb && cyc == ws + 7 && !grst));
         chk("trunc", 32'(trunc), 32'(grst && eb && cyc != ws + 7));
         chk("in_ready", 32'(in_ready), 32'(!pf));
         xfer = in_valid && !pf;
         if (grst) begin
            while (q.size() > 0 && q[q.size()-1].cyc > cyc) void'(q.pop_back());
            if (pf) begin
               ws = cyc + 1;
               we = cyc + 8;
               push_window(cyc, pw);
               pf = 1'b0;
            end else if (we > cyc) begin
               we = cyc;
            end
         end
         if (xfer) begin
            pf = 1'b1;
            pw = in_data;
         end
         @(posedge clk);
         #1;
         cyc++;
         grst = 1'b0;
         if (xfer) in_valid = 1'b0;
      end
   endtask

   task automatic do_reset;
      rst      = 1'b1;
      grst     = 1'b0;
      in_valid = 1'b0;
      #2;
      chk("rst_spikes", 32'(spikes_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(window_done), 32'd0);
      chk("rst_trunc", 32'(trunc), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);
      q.delete();
      pf = 1'b0;
      ws = -100;
      we = -100;
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc++;
   endtask

   initial begin
      rst      = 1'b1;
      grst     = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      do_reset();

      // Basic window: lines at slots 2 and 5
      offer({3'd5, 3'd2}); run(1);
      grst = 1'b1; run(10);

      // No-spike code and simultaneous spikes
      offer({3'd7, 3'd0}); run(1);
      grst = 1'b1; run(9);
      offer({3'd0, 3'd0}); run(1);
      grst = 1'b1; run(9);

      // grst with empty pending, word offered in the same cycle
      offer({3'd6, 3'd6}); grst = 1'b1; run(1);
      run(8);

      // Truncation at count 3 with {1,1} pending
      grst = 1'b1; run(1);
      offer({3'd1, 3'd1}); run(3);
      grst = 1'b1; run(1);
      run(9);

      // Back-to-back windows with in_valid held while pending is full
      offer({3'd3, 3'd1}); run(1);
      grst = 1'b1; run(1);
      offer({3'd4, 3'd0}); run(1);
      offer({3'd2, 3'd5}); run(6);
      grst = 1'b1; run(1);
      run(7);
      grst = 1'b1; run(1);
      run(9);

      // Reset at count 2 with a pending word
      offer({3'd6, 3'd2}); run(1);
      grst = 1'b1; run(1);
      offer({3'd0, 3'd3}); run(2);
      chk("pre_rst_spikes", 32'(spikes_out), 32'd1);
      do_reset();
      grst = 1'b1; run(1);
      run(9);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
